// File: rtl/lz77_pkg.sv
// lz77_pkg: shared types and default sizing for the streaming LZ77 encoder.
// Provides the FSM state enum, the default parameter constants, a width helper
// and the token record {offset, match_len, char_nxt} at the default widths.
package lz77_pkg;

  // Bit width of a field that must hold values up to v-1; never below one bit.
  function automatic int min1_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_SEARCH_LEN    = 9;
  localparam int DEF_LOOKAHEAD_LEN = 8;
  localparam int DEF_BUF_DEPTH     = 32;
  localparam int DEF_OFF_W         = min1_clog2(DEF_SEARCH_LEN);
  localparam int DEF_LEN_W         = min1_clog2(DEF_LOOKAHEAD_LEN);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_OFF_W-1:0]  offset;
    logic [DEF_LEN_W-1:0]  match_len;
    logic [DEF_DATA_W-1:0] char_nxt;
  } token_t;

endpackage

// File: rtl/lz77_enc_stream_match_len.sv
// lz77_match_len: counts how many leading symbol pairs are equal, stopping at
// the first difference or once the count reaches i_max.
//   i_cand  candidate symbols, pair k at [k*DATA_W +: DATA_W]
//   i_look  look-ahead symbols, same packing
//   i_max   cap on the returned count
//   o_len   leading-match count (0..i_max)
module lz77_match_len #(
  parameter int DATA_W        = 8,
  parameter int LOOKAHEAD_LEN = 8,
  parameter int LEN_W         = 3
) (
  input  logic [LOOKAHEAD_LEN*DATA_W-1:0] i_cand,
  input  logic [LOOKAHEAD_LEN*DATA_W-1:0] i_look,
  input  logic [LEN_W-1:0]                i_max,
  output logic [LEN_W-1:0]                o_len
);

  logic             w_run;
  logic [LEN_W-1:0] w_cnt;

  // Leading-equal count; w_run drops at the first mismatch or at the cap.
  always_comb begin
    w_run = 1'b1;
    w_cnt = '0;
    for (int k = 0; k < LOOKAHEAD_LEN; k++) begin
      if (w_run && (k < int'(i_max)) &&
          (i_cand[k*DATA_W +: DATA_W] == i_look[k*DATA_W +: DATA_W])) begin
        w_cnt = w_cnt + LEN_W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign o_len = w_cnt;

endmodule

// File: rtl/lz77_enc_stream.sv
// lz77_enc_stream: loads a block of up to BUF_DEPTH symbols, then emits one
// (offset, match_len, char_nxt) token per handshake, scanning one search
// candidate per cycle from the most recent backwards.
//   clk, reset (async, active-low)
//   code_valid/chardata  symbol input, accepted only while not busy
//   out_ready            consumer accepts the presented token
//   busy                 block is being encoded
//   valid/offset/match_len/char_nxt  token output, held until accepted
//   done                 one-cycle pulse after the last token is accepted
//   ovf                  block overflowed; clears on the next block's first symbol
module lz77_enc_stream
  import lz77_pkg::*;
#(
  parameter int  DATA_W        = DEF_DATA_W,
  parameter int  SEARCH_LEN    = DEF_SEARCH_LEN,
  parameter int  LOOKAHEAD_LEN = DEF_LOOKAHEAD_LEN,
  parameter int  BUF_DEPTH     = DEF_BUF_DEPTH,
  localparam int OFF_W         = min1_clog2(SEARCH_LEN),
  localparam int LEN_W         = min1_clog2(LOOKAHEAD_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [DATA_W-1:0] chardata,
  input  logic              out_ready,
  output logic              busy,
  output logic              valid,
  output logic [OFF_W-1:0]  offset,
  output logic [LEN_W-1:0]  match_len,
  output logic [DATA_W-1:0] char_nxt,
  output logic              done,
  output logic              ovf
);

  localparam int AW    = min1_clog2(BUF_DEPTH);
  localparam int IDX_W = AW + 1;

  state_e                r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_buf [BUF_DEPTH];
  logic [IDX_W-1:0]      r_len, r_p, r_j;
  logic [LEN_W-1:0]      r_best_len;
  logic [OFF_W-1:0]      r_best_off;
  logic                  r_valid, r_busy, r_done, r_ovf;
  logic [OFF_W-1:0]      r_offset;
  logic [LEN_W-1:0]      r_match_len;
  logic [DATA_W-1:0]     r_char_nxt;

  logic [LOOKAHEAD_LEN*DATA_W-1:0] w_cand_flat, w_look_flat;
  logic [IDX_W-1:0]      w_rem, w_lo, w_p_next;
  logic [LEN_W-1:0]      w_lmax, w_ml_max, w_cur_len, w_fin_len;
  logic [OFF_W-1:0]      w_cur_off, w_fin_off;
  logic [DATA_W-1:0]     w_char;
  logic                  w_better, w_last, w_accept;
  logic                  w_valid_nxt, w_busy_nxt, w_done_nxt;

  // Candidate and look-ahead windows; positions past the buffer read as zero.
  always_comb begin
    w_cand_flat = '0;
    w_look_flat = '0;
    for (int k = 0; k < LOOKAHEAD_LEN; k++) begin
      int ci;
      int li;
      ci = int'(r_j) + k;
      li = int'(r_p) + k;
      if (ci < BUF_DEPTH) w_cand_flat[k*DATA_W +: DATA_W] = r_buf[ci[AW-1:0]];
      else                w_cand_flat[k*DATA_W +: DATA_W] = '0;
      if (li < BUF_DEPTH) w_look_flat[k*DATA_W +: DATA_W] = r_buf[li[AW-1:0]];
      else                w_look_flat[k*DATA_W +: DATA_W] = '0;
    end
  end

  // Match cap, oldest allowed candidate and the running-best update.
  always_comb begin
    if (r_len > r_p) w_rem = r_len - r_p - IDX_W'(1);
    else             w_rem = '0;
    if (int'(w_rem) > LOOKAHEAD_LEN - 1) w_lmax = LEN_W'(LOOKAHEAD_LEN - 1);
    else                                 w_lmax = LEN_W'(w_rem);
    if (int'(r_p) >= SEARCH_LEN) w_lo = r_p - IDX_W'(SEARCH_LEN);
    else                         w_lo = '0;
    // p==0 has no candidate: force the cap to zero so the literal path wins.
    if (r_p == '0) w_ml_max = '0;
    else           w_ml_max = w_lmax;
    w_cur_off = OFF_W'(r_p - r_j - IDX_W'(1));
    // Strictly greater only, so on ties the nearer (earlier-scanned) one stays.
    w_better  = (w_cur_len > r_best_len);
    w_fin_len = w_better ? w_cur_len : r_best_len;
    if (w_fin_len == '0) w_fin_off = '0;
    else if (w_better)   w_fin_off = w_cur_off;
    else                 w_fin_off = r_best_off;
    w_last    = (r_p == '0) || (r_j == w_lo) || (w_fin_len == w_lmax);
    w_accept  = r_valid & out_ready;
    w_p_next  = r_p + IDX_W'(r_match_len) + IDX_W'(1);
  end

  // Literal that follows the chosen match.
  always_comb begin
    int ni;
    ni = int'(r_p) + int'(w_fin_len);
    if (ni < BUF_DEPTH) w_char = r_buf[ni[AW-1:0]];
    else                w_char = '0;
  end

  lz77_match_len #(
    .DATA_W        (DATA_W),
    .LOOKAHEAD_LEN (LOOKAHEAD_LEN),
    .LEN_W         (LEN_W)
  ) u_match_len (
    .i_cand (w_cand_flat),
    .i_look (w_look_flat),
    .i_max  (w_ml_max),
    .o_len  (w_cur_len)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   if (!code_valid && (r_len != '0)) w_state_nxt = ST_SEARCH;
                 else                              w_state_nxt = ST_LOAD;
      ST_SEARCH: if (w_last) w_state_nxt = ST_EMIT;
                 else        w_state_nxt = ST_SEARCH;
      ST_EMIT:   if (w_accept && (w_p_next == r_len)) w_state_nxt = ST_DONE;
                 else if (w_accept)                   w_state_nxt = ST_SEARCH;
                 else                                 w_state_nxt = ST_EMIT;
      ST_DONE:   w_state_nxt = ST_LOAD;
      default:   w_state_nxt = ST_LOAD;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    w_valid_nxt = (w_state_nxt == ST_EMIT);
    w_busy_nxt  = (w_state_nxt != ST_LOAD);
    w_done_nxt  = (w_state_nxt == ST_DONE);
  end

  // Block buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD) && code_valid && (int'(r_len) < BUF_DEPTH)) begin
      r_buf[r_len[AW-1:0]] <= chardata;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len       <= '0;
      r_p         <= '0;
      r_j         <= '0;
      r_best_len  <= '0;
      r_best_off  <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_offset    <= '0;
      r_match_len <= '0;
      r_char_nxt  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      case (r_state)
        ST_LOAD: begin
          r_best_len <= '0;
          r_best_off <= '0;
          if (code_valid) begin
            if (int'(r_len) < BUF_DEPTH) begin
              r_len <= r_len + IDX_W'(1);
              if (r_len == '0) r_ovf <= 1'b0;
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end
        ST_SEARCH: begin
          if (w_last) begin
            r_offset    <= w_fin_off;
            r_match_len <= w_fin_len;
            r_char_nxt  <= w_char;
          end else begin
            r_j <= r_j - IDX_W'(1);
            if (w_better) begin
              r_best_len <= w_cur_len;
              r_best_off <= w_cur_off;
            end
          end
        end
        ST_EMIT: begin
          if (w_accept) begin
            r_p        <= w_p_next;
            r_j        <= w_p_next - IDX_W'(1);
            r_best_len <= '0;
            r_best_off <= '0;
          end
        end
        ST_DONE: begin
          r_len <= '0;
          r_p   <= '0;
        end
        default: begin
          r_len <= '0;
          r_p   <= '0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign offset    = r_offset;
  assign match_len = r_match_len;
  assign char_nxt  = r_char_nxt;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_lz77_enc_stream.sv
// Directed bench for lz77_enc_stream at default parameters. Expected tokens
// are hand-derived from the block contents.
module tb_lz77_enc_stream;
  import lz77_pkg::*;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [7:0] chardata;
  logic       out_ready;
  logic       busy, valid, done, ovf;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  lz77_enc_stream u_dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .chardata   (chardata),
    .out_ready  (out_ready),
    .busy       (busy),
    .valid      (valid),
    .offset     (offset),
    .match_len  (match_len),
    .char_nxt   (char_nxt),
    .done       (done),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic token_t tok(input int o, input int l, input logic [7:0] c);
    token_t t;
    t.offset    = DEF_OFF_W'(o);
    t.match_len = DEF_LEN_W'(l);
    t.char_nxt  = c;
    return t;
  endfunction

  task automatic load_sym(input logic [7:0] c);
    @(negedge clk);
    code_valid = 1'b1;
    chardata   = c;
  endtask

  task automatic load_end();
    @(negedge clk);
    code_valid = 1'b0;
    chardata   = 8'h00;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) load_sym(s[i]);
    load_end();
  endtask

  // Waits (bounded) for a token and checks it; accepted on the next edge if out_ready=1.
  task automatic expect_tok(input string tag, input token_t t);
    int n;
    n = 0;
    @(negedge clk);
    while ((valid !== 1'b1) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".valid"}, 32'(valid), 32'd1);
    check_eq({tag, ".busy"},  32'(busy), 32'd1);
    check_eq({tag, ".off"},   32'(offset), 32'(t.offset));
    check_eq({tag, ".len"},   32'(match_len), 32'(t.match_len));
    check_eq({tag, ".chr"},   32'(char_nxt), 32'(t.char_nxt));
  endtask

  task automatic finish_block(input string tag, input int d0);
    repeat (4) @(negedge clk);
    check_eq({tag, ".done_once"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".idle_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int d0;
    string s;
    reset      = 1'b1;
    code_valid = 1'b0;
    chardata   = 8'h00;
    out_ready  = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.valid", 32'(valid), 32'd0);
    check_eq("rst.busy",  32'(busy), 32'd0);
    check_eq("rst.done",  32'(done), 32'd0);
    check_eq("rst.ovf",   32'(ovf), 32'd0);
    check_eq("rst.off",   32'(offset), 32'd0);
    check_eq("rst.len",   32'(match_len), 32'd0);
    check_eq("rst.chr",   32'(char_nxt), 32'd0);
    reset = 1'b1;

    // Overlapping run.
    out_ready = 1'b1;
    d0 = done_cnt;
    load_str("aaaaaaa");
    check_eq("a7.load_busy", 32'(busy), 32'd0);
    expect_tok("a7.t0", tok(0, 0, 8'h61));
    expect_tok("a7.t1", tok(0, 5, 8'h61));
    finish_block("a7", d0);

    // Repeat at distance 3.
    d0 = done_cnt;
    load_str("abcabcd");
    expect_tok("abc.t0", tok(0, 0, "a"));
    expect_tok("abc.t1", tok(0, 0, "b"));
    expect_tok("abc.t2", tok(0, 0, "c"));
    expect_tok("abc.t3", tok(2, 3, "d"));
    finish_block("abc", d0);

    // Match at the window edge (distance 9).
    d0 = done_cnt;
    s = "abcdefghiab";
    load_str(s);
    for (int i = 0; i < 9; i++) expect_tok($sformatf("win9.lit%0d", i), tok(0, 0, s[i]));
    expect_tok("win9.t9", tok(8, 1, "b"));
    finish_block("win9", d0);

    // Overflow: 40 symbols, only 32 kept.
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) load_sym(8'h7a);
    load_end();
    check_eq("ovf.set", 32'(ovf), 32'd1);
    expect_tok("ovf.t0", tok(0, 0, 8'h7a));
    expect_tok("ovf.t1", tok(0, 7, 8'h7a));
    expect_tok("ovf.t2", tok(0, 7, 8'h7a));
    expect_tok("ovf.t3", tok(0, 7, 8'h7a));
    expect_tok("ovf.t4", tok(0, 6, 8'h7a));
    finish_block("ovf", d0);
    check_eq("ovf.sticky", 32'(ovf), 32'd1);

    // Next block: ovf clears on its first stored symbol; 'a' at distance 10 is out of window.
    d0 = done_cnt;
    s = "abcdefghijab";
    load_sym(s[0]);
    check_eq("ovf.before_first", 32'(ovf), 32'd1);
    load_sym(s[1]);
    check_eq("ovf.cleared", 32'(ovf), 32'd0);
    for (int i = 2; i < s.len(); i++) load_sym(s[i]);
    load_end();
    for (int i = 0; i < 10; i++) expect_tok($sformatf("win10.lit%0d", i), tok(0, 0, s[i]));
    expect_tok("win10.t10", tok(0, 0, "a"));
    expect_tok("win10.t11", tok(0, 0, "b"));
    finish_block("win10", d0);

    // Backpressure: first token held for 5 cycles, accepted on the 6th.
    d0 = done_cnt;
    out_ready = 1'b0;
    load_str("abcabcd");
    expect_tok("bp.t0", tok(0, 0, "a"));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp.hold%0d.valid", i), 32'(valid), 32'd1);
      check_eq($sformatf("bp.hold%0d.fields", i), {17'd0, offset, match_len, char_nxt},
               32'(tok(0, 0, "a")));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp.drop", 32'(valid), 32'd0);
    expect_tok("bp.t1", tok(0, 0, "b"));
    expect_tok("bp.t2", tok(0, 0, "c"));
    expect_tok("bp.t3", tok(2, 3, "d"));
    finish_block("bp", d0);

    // Reset pulsed while a token is waiting.
    out_ready = 1'b0;
    load_str("abcabcd");
    expect_tok("mid.t0", tok(0, 0, "a"));
    reset = 1'b0;
    #1;
    check_eq("mid.valid", 32'(valid), 32'd0);
    check_eq("mid.busy",  32'(busy), 32'd0);
    check_eq("mid.len",   32'(match_len), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    d0 = done_cnt;
    load_str("xxy");
    expect_tok("post.t0", tok(0, 0, "x"));
    expect_tok("post.t1", tok(0, 1, "y"));
    finish_block("post", d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lz77_enc_stream.md
# lz77_enc_stream

Parametrised LZ77 encoder and successor to the fixed 9/8-window encoder. Loads a block of up to BUF_DEPTH symbols, then emits (offset, match_len, char_nxt) tokens. Search and look-ahead windows, symbol width and buffer depth are configurable. Adds overlapping matches, deterministic tie-break, output backpressure, overflow flag and an end-of-block pulse. Sits between the symbol source and the token packer in the compression path.

## Interface
- DATA_W, 8, symbol width
- SEARCH_LEN, 9, search window size (≥1)
- LOOKAHEAD_LEN, 8, look-ahead window size (≥2)
- BUF_DEPTH, 32, maximum symbols per block
- OFF_W, clog2(SEARCH_LEN), offset width; LEN_W, clog2(LOOKAHEAD_LEN), length width (both derived, not overridden)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- code_valid  in  1  chardata valid in load phase
- chardata  in  DATA_W  input symbol
- out_ready  in  1  consumer accepts token
- busy  out  1  block being encoded; input ignored
- valid  out  1  token present
- offset  out  OFF_W  match distance minus 1
- match_len  out  LEN_W  match length
- char_nxt  out  DATA_W  literal following match
- done  out  1  one-cycle pulse after last token accepted
- ovf  out  1  block exceeded BUF_DEPTH (sticky until next block starts)

## Operation
- States: LOAD, SEARCH, EMIT, DONE.
- LOAD: each code_valid=1 cycle writes chardata at index len; len++. If len==BUF_DEPTH, symbol dropped and ovf set. First code_valid=0 after ≥1 stored symbol → SEARCH; with len==0, stay in LOAD. ovf clears on first write of a new block.
- SEARCH: for look-ahead start p, candidates j from p-1 down to max(0, p-SEARCH_LEN), one per cycle. Match length per candidate is the count of leading equal symbols buf[j+k]==buf[p+k]. Overlap into look-ahead allowed. Capped at Lmax = min(LOOKAHEAD_LEN-1, len-p-1).
- Best = strictly greater length only; ties keep most recent (smallest distance). Compare early-exit on reaching Lmax.
- Token: match_len=best L, offset=(p-j)-1 when L>0, else 0. char_nxt=buf[p+L].
- EMIT: valid=1, fields held stable until out_ready=1. On handshake, p += L+1. Then p==len → DONE, else SEARCH.
- DONE: done=1 for one cycle, clear len/p, → LOAD.
- Arithmetic: indices clog2(BUF_DEPTH)+1 bits, no wrap; offset ≤ SEARCH_LEN-1 and match_len ≤ LOOKAHEAD_LEN-1 always fit.

## Timing
- Reset values: valid=0, busy=0, done=0, ovf=0, offset=0, match_len=0, char_nxt=0; state LOAD, len=0, p=0.
- busy=1 from the cycle SEARCH is entered through the DONE cycle; 0 in LOAD.
- SEARCH lasts max(1, number of candidates) cycles; fewer on early exit. p==0 takes 1 cycle and yields (0,0,buf[0]).
- valid rises the cycle after SEARCH ends. Accept = valid & out_ready. valid drops the next cycle (no back-to-back tokens).
- out_ready while valid=0 is ignored. code_valid while busy=1 is ignored.
- Reset mid-block aborts: outputs return to reset values asynchronously, buffer contents are don't-care.

## Structure
- Package lz77_pkg: state enum, default parameter constants, token struct {offset, match_len, char_nxt} parameterised through localparams.
- Sub-module lz77_match_len: combinational compare of LOOKAHEAD_LEN symbol pairs → leading-match count capped at a max input. Instantiated once, fed by the candidate mux.

## Test plan
- "aaaaaaa" (0x61×7), out_ready=1 → (0,0,'a') then (0,5,'a') via overlap; done pulses once.
- "abcabcd" → (0,0,a),(0,0,b),(0,0,c),(2,3,'d').
- "abcdefghiab" → nine literal tokens then (8,1,'b'). With "abcdefghijab", 'a' at distance 10 is out of window → (0,0,'a'),(0,0,'b').
- Backpressure: out_ready=0 for 5 cycles during EMIT → valid and fields stable, no advance; token accepted on the 6th cycle.
- 40 symbols with BUF_DEPTH=32 → ovf=1, only the first 32 encoded. ovf clears on the next block's first symbol.
- reset=0 pulsed mid-EMIT → valid/busy 0 immediately. A new 3-symbol block then encodes correctly.
